// File: rtl/fpu_pkg.sv
// Shared fp32 constants, field widths and the post-normalisation FSM state type.
// Pure declarations, no logic.
package fpu_pkg;
    localparam int EXP_BIAS  = 127;
    localparam int EXP_MAX   = 255;
    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    localparam int FP_W      = 32;
    localparam int FP_EXP_W  = 8;
    localparam int FP_FRAC_W = 23;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        RND  = 2'd2,
        HOLD = 2'd3
    } pn_state_e;
endpackage

// File: rtl/fdiv_post_norm_if.sv
// Divider-to-result handshake bundle: operand side (valid/ready) and result side (valid/ready).
// master drives operands and out_ready; slave is the post-normalisation stage.
interface fdiv_post_norm_if #(
    parameter int QW   = 48,
    parameter int MW   = 24,
    parameter int EXPW = 10
);
    logic                   in_valid;
    logic                   in_ready;
    logic [QW-1:0]          quo;
    logic [QW-1:0]          rem;
    logic [MW-1:0]          divisor;
    logic signed [EXPW-1:0] exp_in;
    logic                   sign_in;
    logic                   in_special;
    logic [31:0]            special_val;
    logic                   out_valid;
    logic                   out_ready;
    logic [31:0]            result;
    logic                   overflow;
    logic                   underflow;
    logic                   inexact;

    modport master (
        output in_valid, quo, rem, divisor, exp_in, sign_in, in_special, special_val, out_ready,
        input  in_ready, out_valid, result, overflow, underflow, inexact
    );

    modport slave (
        input  in_valid, quo, rem, divisor, exp_in, sign_in, in_special, special_val, out_ready,
        output in_ready, out_valid, result, overflow, underflow, inexact
    );
endinterface

// File: rtl/fdiv_round_rne.sv
// Combinational round-to-nearest-even, carry exponent fix-up and fp32 pack with
// overflow-to-Inf / flush-to-zero. Zero latency, no flow control.
module fdiv_round_rne
    import fpu_pkg::*;
#(
    parameter int MW   = 24,
    parameter int EXPW = 10
) (
    input  logic [MW-1:0]          mant,
    input  logic                   g,
    input  logic                   s,
    input  logic signed [EXPW-1:0] exp_in,
    input  logic                   sign,
    output logic [31:0]            result,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   inexact
);
    logic              up;
    logic [MW:0]       sum;
    logic [MW-1:0]     mant_r;
    logic [EXPW:0]     exp_r;
    logic              exp_neg;
    logic              unused_bits;

    assign unused_bits = mant_r[MW-1];

    always_comb begin
        up     = g & (s | mant[0]);
        sum    = {1'b0, mant} + {{MW{1'b0}}, up};
        mant_r = sum[MW-1:0];
        exp_r  = {exp_in[EXPW-1], exp_in};
        // Rounding 0xFFFFFF up lands exactly on the next binade.
        if (sum[MW]) begin
            mant_r = {1'b1, {(MW-1){1'b0}}};
            exp_r  = exp_r + (EXPW+1)'(1);
        end
        exp_neg = exp_r[EXPW];

        result    = {sign, exp_r[FP_EXP_W-1:0], mant_r[FP_FRAC_W-1:0]};
        overflow  = 1'b0;
        underflow = 1'b0;
        inexact   = g | s;
        if (!exp_neg && (exp_r[EXPW-1:0] >= EXPW'(EXP_MAX))) begin
            result   = {sign, POS_INF[FP_W-2:0]};
            overflow = 1'b1;
            inexact  = 1'b1;
        end else if (exp_neg || (exp_r == '0)) begin
            result    = {sign, {(FP_W-1){1'b0}}};
            underflow = 1'b1;
            inexact   = 1'b1;
        end
    end
endmodule

// File: rtl/fdiv_post_norm.sv
// Post-normalise, recover guard/sticky, RNE-round and pack the mantissa divider output.
// Normal path out_valid after 3 edges, bypass after 1; result held stable until out_ready.
module fdiv_post_norm
    import fpu_pkg::*;
#(
    parameter int QW   = 48,
    parameter int MW   = 24,
    parameter int EXPW = 10
) (
    input  logic             clk,
    input  logic             rst,
    fdiv_post_norm_if.slave  bus
);
    pn_state_e              state;
    pn_state_e              state_nxt;

    logic [MW:0]            cap_quo;
    logic [QW-1:0]          cap_rem;
    logic [MW-1:0]          cap_div;
    logic signed [EXPW-1:0] cap_exp;
    logic                   cap_sign;

    logic [MW-1:0]          norm_mant;
    logic                   norm_g;
    logic                   norm_s;
    logic signed [EXPW-1:0] norm_exp;

    logic [MW-1:0]          mant_c;
    logic                   g_c;
    logic                   s_c;
    logic signed [EXPW-1:0] exp_c;
    logic [QW:0]            rem2;
    logic [QW:0]            div_ext;
    logic [QW:0]            rem2_sub;

    logic [31:0]            rnd_result;
    logic                   rnd_ovf;
    logic                   rnd_unf;
    logic                   rnd_inx;

    logic [31:0]            res_q;
    logic                   ovf_q;
    logic                   unf_q;
    logic                   inx_q;
    logic                   out_valid_q;
    logic                   out_valid_nxt;
    logic                   accept;
    logic                   unused_quo;

    // Upper quotient bits are never set for normalised operands.
    assign unused_quo = |bus.quo[QW-1:MW+1];
    assign accept     = (state == IDLE) && bus.in_valid;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.in_valid) state_nxt = bus.in_special ? HOLD : NORM;
            NORM: state_nxt = RND;
            RND:  state_nxt = HOLD;
            HOLD: if (out_valid_q && bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = out_valid_q;
        bus.result    = res_q;
        bus.overflow  = ovf_q;
        bus.underflow = unf_q;
        bus.inexact   = inx_q;
        out_valid_nxt = (state == HOLD) && !(out_valid_q && bus.out_ready);
    end

    // Quotient is either in [2^24, 2^25) or [2^23, 2^24); the short case needs one
    // extra remainder bit to recover the guard.
    always_comb begin
        rem2     = {cap_rem, 1'b0};
        div_ext  = {{(QW+1-MW){1'b0}}, cap_div};
        rem2_sub = rem2;
        if (cap_quo[MW]) begin
            mant_c = cap_quo[MW:1];
            g_c    = cap_quo[0];
            s_c    = |cap_rem;
            exp_c  = cap_exp;
        end else begin
            mant_c   = cap_quo[MW-1:0];
            g_c      = (rem2 >= div_ext);
            rem2_sub = rem2 - (g_c ? div_ext : '0);
            s_c      = |rem2_sub;
            exp_c    = cap_exp - EXPW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cap_quo  <= bus.quo[MW:0];
            cap_rem  <= bus.rem;
            cap_div  <= bus.divisor;
            cap_exp  <= bus.exp_in;
            cap_sign <= bus.sign_in;
        end
        if (state == NORM) begin
            norm_mant <= mant_c;
            norm_g    <= g_c;
            norm_s    <= s_c;
            norm_exp  <= exp_c;
        end
    end

    fdiv_round_rne #(
        .MW   (MW),
        .EXPW (EXPW)
    ) u_round (
        .mant      (norm_mant),
        .g         (norm_g),
        .s         (norm_s),
        .exp_in    (norm_exp),
        .sign      (cap_sign),
        .result    (rnd_result),
        .overflow  (rnd_ovf),
        .underflow (rnd_unf),
        .inexact   (rnd_inx)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inx_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_nxt;
            if (accept) begin
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
                inx_q <= 1'b0;
                if (bus.in_special) res_q <= bus.special_val;
            end else if (state == RND) begin
                res_q <= rnd_result;
                ovf_q <= rnd_ovf;
                unf_q <= rnd_unf;
                inx_q <= rnd_inx;
            end
        end
    end
endmodule

// File: tb/tb_fdiv_post_norm.sv
// Directed and random checks of fdiv_post_norm against an exact-division RNE reference.
module tb_fdiv_post_norm;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fdiv_post_norm_if #(.QW(48), .MW(24), .EXPW(10)) bus ();

    fdiv_post_norm #(.QW(48), .MW(24), .EXPW(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: exact quotient of the original mantissas, rounded to 24 bits RNE.
    task automatic model(input logic [23:0] ma, input logic [23:0] mb, input int ex, input bit sg,
                         output logic [31:0] r, output logic [2:0] fl);
        longint unsigned num, q, rr;
        int e;
        bit ix;
        if (ma >= mb) begin num = longint'(ma) << 23; e = ex;     end
        else          begin num = longint'(ma) << 24; e = ex - 1; end
        q  = num / longint'(mb);
        rr = num % longint'(mb);
        ix = (rr != 0);
        if ((2 * rr > longint'(mb)) || ((2 * rr == longint'(mb)) && ((q & 1) == 1))) q = q + 1;
        if (q == (64'd1 << 24)) begin q = 64'd1 << 23; e = e + 1; end
        if (e >= 255) begin
            r = sg ? 32'hFF800000 : 32'h7F800000; fl = 3'b101;
        end else if (e <= 0) begin
            r = sg ? 32'h80000000 : 32'h00000000; fl = 3'b011;
        end else begin
            r  = (32'(sg) << 31) | (32'(e) << 23) | 32'(q & 64'h7FFFFF);
            fl = {2'b00, ix};
        end
    endtask

    task automatic drive(input bit sp, input logic [31:0] sv, input logic [47:0] q, input logic [47:0] r,
                         input logic [23:0] d, input logic [9:0] e, input bit sg);
        bus.in_valid    = 1'b1;
        bus.in_special  = sp;
        bus.special_val = sv;
        bus.quo         = q;
        bus.rem         = r;
        bus.divisor     = d;
        bus.exp_in      = e;
        bus.sign_in     = sg;
    endtask

    task automatic do_op(input string tag, input bit sp, input logic [31:0] sv, input logic [47:0] q,
                         input logic [47:0] r, input logic [23:0] d, input logic [9:0] e, input bit sg,
                         input logic [31:0] xr, input logic [2:0] xfl);
        int n;
        if (!sp && ((q[47:25] != 0) || (q[24:23] == 2'b00)))
            $display("note: %s uses an out-of-range quotient %h", tag, q);
        @(negedge clk);
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        drive(sp, sv, q, r, d, e, sg);
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".latency"}, 32'(n), sp ? 32'd1 : 32'd3);
        chk({tag, ".result"}, bus.result, xr);
        chk({tag, ".flags"}, {29'd0, bus.overflow, bus.underflow, bus.inexact}, {29'd0, xfl});
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({tag, ".drain"}, {30'd0, bus.out_valid, bus.in_ready}, 32'b01);
    endtask

    initial begin
        logic [31:0] xr;
        logic [2:0]  xfl;
        logic [23:0] ma, mb;
        logic [47:0] a, q, r;
        int ex, n;
        bit sg;

        drive(1'b0, 32'h0, 48'h0, 48'h0, 24'h800000, 10'd0, 1'b0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.in_ready",  32'(bus.in_ready), 32'd1);
        chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset.result",    bus.result, 32'h0);
        chk("reset.flags",     {29'd0, bus.overflow, bus.underflow, bus.inexact}, 32'd0);
        rst = 1'b1;

        do_op("six_by_two", 0, 0, 48'h1800000, 48'h0, 24'h800000, 10'd128, 0, 32'h40400000, 3'b000);
        do_op("one_by_three", 0, 0, 48'hAAAAAA, 48'h800000, 24'hC00000, 10'd126, 0, 32'h3EAAAAAB, 3'b001);
        do_op("round_carry", 0, 0, 48'h1FFFFFF, 48'h1, 24'h800000, 10'd127, 0, 32'h40000000, 3'b001);
        do_op("overflow", 0, 0, 48'h1800000, 48'h0, 24'h800000, 10'd260, 0, 32'h7F800000, 3'b101);
        do_op("underflow", 0, 0, 48'h1000000, 48'h0, 24'h800000, 10'd0, 1, 32'h80000000, 3'b011);
        do_op("special", 1, 32'h7FC00000, 48'h1800000, 48'h0, 24'h800000, 10'd128, 0, 32'h7FC00000, 3'b000);

        // Hold the result under backpressure while new operands are offered.
        @(negedge clk);
        drive(0, 0, 48'h1800000, 48'h0, 24'h800000, 10'd128, 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        chk("bp.latency", 32'(n), 32'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1, 32'hDEADBEEF, 48'h1000000, 48'h0, 24'h800000, 10'd5, 1);
            @(posedge clk); #1;
            chk("bp.in_ready",  32'(bus.in_ready), 32'd0);
            chk("bp.out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp.result",    bus.result, 32'h40400000);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("bp.no_stray", {30'd0, bus.out_valid, bus.in_ready}, 32'b01);

        // Reset while in NORM discards the operation.
        @(negedge clk);
        drive(0, 0, 48'h1800000, 48'h0, 24'h800000, 10'd128, 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("midrst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst.result",    bus.result, 32'h0);
        chk("midrst.in_ready",  32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("midrst.discarded", 32'(bus.out_valid), 32'd0);

        for (int i = 0; i < 40; i++) begin
            ma = 24'h800000 | 24'($urandom_range(0, 24'h7FFFFF));
            mb = 24'h800000 | 24'($urandom_range(0, 24'h7FFFFF));
            if (i % 8 == 0) mb = ma;
            ex = int'($urandom_range(0, 300)) - 20;
            sg = 1'($urandom_range(0, 1));
            a  = {ma, 24'h0};
            q  = a / {24'h0, mb};
            r  = a % {24'h0, mb};
            model(ma, mb, ex, sg, xr, xfl);
            do_op($sformatf("rand%0d", i), 0, 0, q, r, mb, 10'(ex), sg, xr, xfl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
